// File: rtl/disk_controller_spi_master.sv
// SPI master for the disk controller: configurable width, divider, mode, chip selects and bit order.
// Define DISK_CONTROLLER_SPI_LSB_FIRST_EN to honour lsb_first_i; otherwise transfers are MSB first.
`timescale 1ns/1ps

module disk_controller_spi_master #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV_W = 8,
    parameter int unsigned NCS   = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             strobe_i,
    input  logic [WIDTH-1:0] dat_i,
    input  logic [NCS-1:0]   cs_i,
    input  logic             cs_hold_i,
    input  logic             cpol_i,
    input  logic             cpha_i,
    input  logic             lsb_first_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] dat_o,
    output logic             sck_o,
    output logic             mosi_o,
    input  logic             miso_i,
    output logic [NCS-1:0]   cs_no
);

    localparam int unsigned TW = $clog2(2 * WIDTH + 1);
    localparam logic [TW-1:0] TGL_LAST = TW'(2 * WIDTH);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

    state_e           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic [TW-1:0]    r_tgl, w_tgl_nxt;
    logic [WIDTH-1:0] r_tx, w_tx_nxt;
    logic [WIDTH-1:0] r_rx, w_rx_nxt;
    logic [WIDTH-1:0] r_dat, w_dat_nxt;
    logic [NCS-1:0]   r_cs, w_cs_nxt;
    logic             r_cpha, w_cpha_nxt;
    logic             r_lsb, w_lsb_nxt;
    logic             r_hold, w_hold_nxt;
    logic             r_sck, w_sck_nxt;
    logic             r_mosi, w_mosi_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;

    logic             w_lsb_in;
    logic             w_toggle;
    logic             w_cnt_wrap;
    logic [TW-1:0]    w_tgl_inc;

`ifdef DISK_CONTROLLER_SPI_LSB_FIRST_EN
    assign w_lsb_in = lsb_first_i;
`else
    logic w_unused_lsb;
    assign w_unused_lsb = lsb_first_i;
    assign w_lsb_in     = 1'b0;
`endif

    assign w_cnt_wrap = (r_cnt == r_div);
    assign w_tgl_inc  = r_tgl + TW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_tgl_nxt   = r_tgl;
        w_tx_nxt    = r_tx;
        w_rx_nxt    = r_rx;
        w_dat_nxt   = r_dat;
        w_cs_nxt    = r_cs;
        w_cpha_nxt  = r_cpha;
        w_lsb_nxt   = r_lsb;
        w_hold_nxt  = r_hold;
        w_sck_nxt   = r_sck;
        w_mosi_nxt  = r_mosi;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_toggle    = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_sck_nxt = cpol_i;
                if (strobe_i) begin
                    w_div_nxt   = div_i;
                    w_cpha_nxt  = cpha_i;
                    w_lsb_nxt   = w_lsb_in;
                    w_hold_nxt  = cs_hold_i;
                    w_cs_nxt    = ~cs_i;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_tgl_nxt   = '0;
                    w_state_nxt = StSetup;
                    // CPHA=0 needs the first bit on the wire before the first leading edge
                    if (!cpha_i) begin
                        w_mosi_nxt = w_lsb_in ? dat_i[0] : dat_i[WIDTH-1];
                        w_tx_nxt   = w_lsb_in ? (dat_i >> 1) : (dat_i << 1);
                    end else begin
                        w_tx_nxt   = dat_i;
                    end
                end
            end
            StSetup: begin
                if (w_cnt_wrap) begin
                    w_cnt_nxt   = '0;
                    w_toggle    = 1'b1;
                    w_state_nxt = StShift;
                end else begin
                    w_cnt_nxt   = r_cnt + DIV_W'(1);
                end
            end
            StShift: begin
                if (w_cnt_wrap) begin
                    w_cnt_nxt = '0;
                    if (r_tgl == TGL_LAST) begin
                        w_state_nxt = StHold;
                    end else begin
                        w_toggle    = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end
            StHold: begin
                if (w_cnt_wrap) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StIdle;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_dat_nxt   = r_rx;
                    if (!r_hold) begin
                        w_cs_nxt = '1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        // Odd toggles are leading edges; the sampling edge is leading for CPHA=0, trailing for CPHA=1
        if (w_toggle) begin
            w_sck_nxt = ~r_sck;
            w_tgl_nxt = w_tgl_inc;
            if (w_tgl_inc[0] ^ r_cpha) begin
                w_rx_nxt = r_lsb ? {miso_i, r_rx[WIDTH-1:1]} : {r_rx[WIDTH-2:0], miso_i};
            end else if (w_tgl_inc != TGL_LAST) begin
                w_mosi_nxt = r_lsb ? r_tx[0] : r_tx[WIDTH-1];
                w_tx_nxt   = r_lsb ? (r_tx >> 1) : (r_tx << 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_div   <= '0;
            r_tgl   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_dat   <= '0;
            r_cs    <= '1;
            r_cpha  <= 1'b0;
            r_lsb   <= 1'b0;
            r_hold  <= 1'b0;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_div   <= w_div_nxt;
            r_tgl   <= w_tgl_nxt;
            r_tx    <= w_tx_nxt;
            r_rx    <= w_rx_nxt;
            r_dat   <= w_dat_nxt;
            r_cs    <= w_cs_nxt;
            r_cpha  <= w_cpha_nxt;
            r_lsb   <= w_lsb_nxt;
            r_hold  <= w_hold_nxt;
            r_sck   <= w_sck_nxt;
            r_mosi  <= w_mosi_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign dat_o  = r_dat;
    assign sck_o  = r_sck;
    assign mosi_o = r_mosi;
    assign cs_no  = r_cs;

endmodule

// File: doc/disk_controller_spi_master.md
# disk_controller_spi_master

Parametrised SPI master for the disk controller, the next generation of the fixed 8-bit mode-0 shifter. Adds configurable transfer width, SCK divider, all four SPI modes, per-device chip-select generation with optional hold across transfers, and bit-order selection. Sits between the disk controller sequencer (strobe/busy handshake) and the external SD/flash pins.

## Interface
- WIDTH, 8, bits per transfer (≥2)
- DIV_W, 8, width of the SCK divider input
- NCS, 1, number of chip-select lines
- clk_i  in  1  system clock
- rst_ni  in  1  reset; one clock, asynchronous and active-low
- strobe_i  in  1  start request, sampled only in IDLE
- dat_i  in  WIDTH  transmit word, latched on accept
- cs_i  in  NCS  chip-select mask (1 = assert that line), latched on accept
- cs_hold_i  in  1  keep CS asserted after this transfer, latched on accept
- cpol_i, cpha_i  in  1 each  SPI mode, latched on accept
- lsb_first_i  in  1  bit order, latched on accept (see Configuration)
- div_i  in  DIV_W  half-period H = div_i+1 clk cycles, latched on accept
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse
- dat_o  out  WIDTH  received word
- sck_o, mosi_o  out  1 each  SPI clock/data out
- miso_i  in  1  SPI data in
- cs_no  out  NCS  active-low chip selects

## Operation
- States: IDLE, SETUP, SHIFT, HOLD.
- Reset values: busy_o=0, done_o=0, dat_o=0, sck_o=0, mosi_o=0, cs_no=all 1, state IDLE, all shift/cfg registers 0.
- IDLE: sck_o <= cpol_i every cycle. strobe_i=1 accepts: latch dat_i, cs_i, cs_hold_i, mode, order, div_i; busy_o<=1; cs_no <= ~cs_i; go SETUP. strobe_i while busy_o=1 is ignored (no queueing).
- SETUP: H cycles, CS asserted, SCK idle. First TX bit on mosi_o from first SETUP cycle when CPHA=0.
- SHIFT: 2·WIDTH SCK toggles, one every H cycles; odd toggles = leading edges, even = trailing.
  - CPHA=0: sample miso_i into RX register on the clk edge that produces each leading edge; advance TX on trailing edges except the last.
  - CPHA=1: present next TX bit on each leading edge (first bit at first leading edge); sample on trailing edges.
- HOLD: H cycles, SCK idle, CS asserted. On exit: dat_o <= RX register, done_o=1 for one cycle, busy_o<=0, go IDLE; cs_no <= all 1 unless latched cs_hold=1.
- Held CS stays asserted in IDLE; next accept overwrites cs_no with new mask; released at end of next transfer with cs_hold=0.
- Divider counter wraps H cycles exactly; div_i=all 1s gives H=2^DIV_W with no overflow (counter DIV_W+1 bits or equivalent).
- dat_o changes only on completion; stable otherwise.
- rst_ni low mid-transfer: all outputs to reset values immediately, transfer discarded, no done_o.

## Timing
- Accept at clk edge n: busy_o=1 and CS asserted from n+1.
- busy_o high exactly (2·WIDTH+2)·H cycles; done_o high in first cycle busy_o=0, dat_o valid same cycle.
- Earliest next accept: the cycle done_o is high (strobe_i=1 that cycle is accepted).
- SCK period 2·H clk cycles; sck_o, mosi_o, cs_no are registered outputs.
- miso_i sampled synchronously; no input synchroniser (board constraint: H≥1 is sufficient setup).

## Configuration
- DISK_CONTROLLER_SPI_LSB_FIRST_EN defined: lsb_first_i=1 shifts TX and RX LSB first; lsb_first_i=0 MSB first.
- Undefined: lsb_first_i ignored, always MSB first; port remains present.

## Test plan
- WIDTH=8, mode 0, div_i=0, dat_i=0xA5, miso loopback -> busy 18 cycles, sck 8 rising edges, dat_o=0xA5, done_o one cycle, cs_no 1→0→1.
- Mode 3, div_i=3, dat_i=0x3C, miso tied 1 -> sck idles high, period 8 clk, busy 72 cycles, mosi bit sequence 0,0,1,1,1,1,0,0, dat_o=0xFF.
- NCS=2, cs_i=2'b10, cs_hold_i=1 then second transfer cs_hold_i=0 -> cs_no=2'b01 held through IDLE gap, released to 2'b11 after second done_o.
- strobe_i pulsed mid-transfer, and strobe_i=1 during done_o cycle -> mid pulse ignored; done-cycle strobe starts back-to-back transfer with busy_o low only that one cycle.
- rst_ni low at 5th SCK edge -> cs_no=all 1, sck_o=0, busy_o=0 asynchronously, no done_o; next transfer 0x5A loopback returns 0x5A.
- DISK_CONTROLLER_SPI_LSB_FIRST_EN defined, lsb_first_i=1, dat_i=0x01, miso loopback -> mosi high on first bit only, dat_o=0x01; macro undefined same stimulus -> mosi high on last bit only, dat_o=0x01.
